// File: rtl/uart_apb_pkg.sv
// -----------------------------------------------------------------------------
// uart_apb_pkg
// Shared definitions for the UART APB initiator:
//   - apb_state_e   : transfer FSM states (IDLE / SETUP / ACCESS)
//   - UART_*        : byte offsets of the UART control registers
//   - *_DEF         : default data / word-address widths
//   - uart_word_addr: converts a byte offset into the word address that the
//                     master drives on addr (bus address bits [11:2])
// Configuration macro used by the files that import this package:
//   UART_APB_TIMEOUT_EN - enables the ACCESS-phase watchdog.
// -----------------------------------------------------------------------------
package uart_apb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 10;

   // Byte offsets of the UART register block.
   localparam logic [11:0] UART_OPS  = 12'h000;
   localparam logic [11:0] UART_TR   = 12'h004;
   localparam logic [11:0] UART_MODE = 12'h008;
   localparam logic [11:0] UART_BAUD = 12'h010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   // Word address seen on the bus for a given byte offset.
   function automatic logic [ADDR_W_DEF-1:0] uart_word_addr(input logic [11:0] byte_off);
      return byte_off[11:2];
   endfunction

endpackage

// File: rtl/uart_apb_wdog.sv
// -----------------------------------------------------------------------------
// uart_apb_wdog
// ACCESS-phase watchdog, instantiated only when UART_APB_TIMEOUT_EN is defined.
// The counter clears on the cycle before ACCESS (start_i) and counts ACCESS
// cycles that end without ready. expire_o is asserted in the ACCESS cycle in
// which the count has reached TIMEOUT-1 and ready is still low, i.e. in the
// TIMEOUT-th consecutive not-ready ACCESS cycle.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   start_i    - 1 in the cycle that precedes ACCESS entry (clears counter)
//   active_i   - 1 while the master is in ACCESS
//   ready_i    - APB slave ready
//   expire_o   - abort request for the current ACCESS cycle
// -----------------------------------------------------------------------------
module uart_apb_wdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic start_i,
   input  logic active_i,
   input  logic ready_i,
   output logic expire_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear on start, count not-ready ACCESS cycles, saturate at LAST.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = '0;
      end else if (active_i && !ready_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // ready in the terminal cycle wins over the abort.
   assign expire_o = active_i && !ready_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_apb_master.sv
// -----------------------------------------------------------------------------
// uart_apb_master
// APB initiator for the UART register block. Takes single read/write commands
// over a valid/ready handshake, runs each one as an APB SETUP then ACCESS
// phase, and returns read data/status on a one-cycle response strobe.
// Zero-wait-state latency: accept N, SETUP N+1, ACCESS N+2, rsp_valid N+3.
// Ports:
//   clk, rstn                    - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          - command handshake (cmd_ready decoded from
//                                  state, 1 only in IDLE out of reset)
//   cmd_write/cmd_addr/cmd_wdata - command direction, word address, data
//   rsp_valid/rsp_rdata/rsp_err  - response strobe, read data, abort flag
//   sel/en/addr/write/wdata      - APB request outputs (registered)
//   rdata/ready                  - APB slave read data and ready
// Configuration:
//   UART_APB_TIMEOUT_EN - when defined, an ACCESS phase that sees TIMEOUT
//                         consecutive not-ready cycles is aborted with
//                         rsp_err=1 and rsp_rdata=0. When undefined, ACCESS
//                         waits indefinitely and rsp_err is tied to 0.
// -----------------------------------------------------------------------------
module uart_apb_master
   import uart_apb_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              sel,
   output logic              en,
   output logic [ADDR_W-1:0] addr,
   output logic              write,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   input  logic              ready
);

   apb_state_e        state_q, state_d;
   logic              sel_q, sel_d;
   logic              en_q, en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              expire_s;

`ifdef UART_APB_TIMEOUT_EN
   logic              rsp_err_q, rsp_err_d;

   uart_apb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk      (clk),
      .rstn     (rstn),
      .start_i  (state_q == ST_SETUP),
      .active_i (state_q == ST_ACCESS),
      .ready_i  (ready),
      .expire_o (expire_s)
   );

   assign rsp_err = rsp_err_q;
`else
   assign expire_s = 1'b0;
   assign rsp_err  = 1'b0;
`endif

   // Next-state and registered-output decode for the transfer FSM.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      en_d        = en_q;
      addr_d      = addr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
`ifdef UART_APB_TIMEOUT_EN
      rsp_err_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            sel_d = 1'b0;
            en_d  = 1'b0;
            // cmd_ready is 1 whenever this state is clocked out of reset.
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               write_d = cmd_write;
               wdata_d = cmd_wdata;
               sel_d   = 1'b1;
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            // ready is deliberately not looked at here.
            sel_d   = 1'b1;
            en_d    = 1'b1;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (ready) begin
               sel_d       = 1'b0;
               en_d        = 1'b0;
               rsp_valid_d = 1'b1;
               if (!write_q) begin
                  rsp_rdata_d = rdata;
               end else begin
                  rsp_rdata_d = rsp_rdata_q;
               end
               state_d     = ST_IDLE;
            end else if (expire_s) begin
               sel_d       = 1'b0;
               en_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
`ifdef UART_APB_TIMEOUT_EN
               rsp_err_d   = 1'b1;
`endif
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_ACCESS;
            end
         end
         default: begin
            sel_d   = 1'b0;
            en_d    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops the bus immediately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         sel_q       <= 1'b0;
         en_q        <= 1'b0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         en_q        <= en_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

`ifdef UART_APB_TIMEOUT_EN
   // Abort flag register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= rsp_err_d;
      end
   end
`endif

   assign cmd_ready = rstn && (state_q == ST_IDLE);
   assign sel       = sel_q;
   assign en        = en_q;
   assign addr      = addr_q;
   assign write     = write_q;
   assign wdata     = wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_master
// Directed plus randomized bench for uart_apb_master. Expected values come
// from a transaction-level model: each command is described by its direction,
// address, data and number of wait states; the model derives how many ACCESS
// cycles it takes, whether it aborts (UART_APB_TIMEOUT_EN builds only), and
// what rsp_rdata must hold afterwards (last read data, 0 after abort/reset).
// -----------------------------------------------------------------------------
module tb_uart_apb_master;
   import uart_apb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int TO = 16;
`ifdef UART_APB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk;
   logic          rstn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          sel;
   logic          en;
   logic [AW-1:0] addr;
   logic          write;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          ready;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   logic [DW-1:0] model_rd = '0;
   int accept_cyc[$];

   uart_apb_master #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .sel       (sel),
      .en        (en),
      .addr      (addr),
      .write     (write),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure accept spacing.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transfer; caller must leave the DUT idle. ready rises in
   // ACCESS cycle index 'waits' (0-based) unless the watchdog fires first.
   task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int waits, input logic [DW-1:0] rd_final);
      bit abort;
      int n_acc;
      abort = TO_EN && (waits >= TO);
      n_acc = abort ? TO : waits + 1;

      chk("cmd_ready_idle", cmd_ready, 64'd1);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      ready     = 1'($urandom_range(0, 1));
      accept_cyc.push_back(cyc);

      step();  // SETUP
      chk("setup_sel", sel, 64'd1);
      chk("setup_en", en, 64'd0);
      chk("setup_addr", addr, 64'(a));
      chk("setup_write", write, 64'(w));
      chk("setup_wdata", wdata, 64'(d));
      chk("setup_rsp_valid", rsp_valid, 64'd0);
      chk("setup_cmd_ready", cmd_ready, 64'd0);
      // cmd_valid stays high with junk payload: must be ignored until IDLE.
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      ready     = 1'($urandom_range(0, 1));  // spurious ready in SETUP

      for (int i = 0; i < n_acc; i++) begin
         step();  // ACCESS cycle i
         chk("access_sel", sel, 64'd1);
         chk("access_en", en, 64'd1);
         chk("access_addr", addr, 64'(a));
         chk("access_wdata", wdata, 64'(d));
         chk("access_rsp_valid", rsp_valid, 64'd0);
         ready = (i == waits);
         rdata = (i == waits) ? rd_final : $urandom;
      end

      step();  // response cycle
      if (abort) begin
         model_rd = '0;
      end else if (!w) begin
         model_rd = rd_final;
      end
      chk("rsp_valid", rsp_valid, 64'd1);
      chk("rsp_err", rsp_err, 64'(abort));
      chk("rsp_rdata", rsp_rdata, 64'(model_rd));
      chk("rsp_sel_drop", sel, 64'd0);
      chk("rsp_en_drop", en, 64'd0);
      chk("rsp_cmd_ready", cmd_ready, 64'd1);
      cmd_valid = 1'b0;
      ready     = 1'b1;
   endtask

   initial begin
      logic [11:0] offs [4];
      offs[0] = UART_OPS;
      offs[1] = UART_TR;
      offs[2] = UART_MODE;
      offs[3] = UART_BAUD;

      rstn      = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rdata     = '0;
      ready     = 1'b1;

      // Reset values.
      #2;
      chk("rst_sel", sel, 64'd0);
      chk("rst_en", en, 64'd0);
      chk("rst_rsp_valid", rsp_valid, 64'd0);
      chk("rst_rsp_err", rsp_err, 64'd0);
      chk("rst_addr", addr, 64'd0);
      chk("rst_wdata", wdata, 64'd0);
      chk("rst_rsp_rdata", rsp_rdata, 64'd0);
      chk("rst_cmd_ready", cmd_ready, 64'd0);
      cmd_valid = 1'b1;  // ignored while in reset
      step();
      step();
      chk("rst_hold_sel", sel, 64'd0);
      cmd_valid = 1'b0;
      rstn      = 1'b1;
      #1;
      chk("post_rst_cmd_ready", cmd_ready, 64'd1);

      // Idle with the slave's ready high: nothing happens.
      for (int i = 0; i < 3; i++) begin
         cmd_addr = AW'($urandom);
         step();
         chk("idle_sel", sel, 64'd0);
         chk("idle_rsp_valid", rsp_valid, 64'd0);
      end

      // Directed: write TR, zero wait states.
      xfer(1'b1, uart_word_addr(UART_TR), 32'h0000_0001, 0, 32'h0);
      // Directed: read with 3 wait states returning 0xA5.
      xfer(1'b0, uart_word_addr(UART_TR), 32'h0, 3, 32'h0000_00A5);
      // The write that follows must not disturb the captured read data.
      xfer(1'b1, uart_word_addr(UART_MODE), 32'h0000_0003, 1, 32'hDEAD_BEEF);

      // Back-to-back: OPS, MODE, BAUD with no gap.
      accept_cyc.delete();
      xfer(1'b1, AW'(12'h000), 32'h11, 0, 32'h0);
      xfer(1'b0, AW'(12'h008), 32'h0, 0, 32'h0000_1234);
      xfer(1'b1, AW'(12'h010), 32'h33, 0, 32'h0);
      chk("b2b_gap1", 64'(accept_cyc[1] - accept_cyc[0]), 64'd3);
      chk("b2b_gap2", 64'(accept_cyc[2] - accept_cyc[1]), 64'd3);

      // Randomized commands against the model.
      for (int k = 0; k < 16; k++) begin
         logic          w;
         logic [AW-1:0] a;
         w = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            a = uart_word_addr(offs[$urandom_range(0, 3)]);
         end else begin
            a = AW'($urandom);
         end
         xfer(w, a, $urandom, int'($urandom_range(0, 5)), $urandom);
         if ($urandom_range(0, 2) == 0) begin
            step();
            chk("gap_rsp_single", rsp_valid, 64'd0);
         end
      end

      // Long stall: completes normally, or aborts when the watchdog is built.
      xfer(1'b0, uart_word_addr(UART_BAUD), 32'h0, 20, 32'h0BAD_F00D);
      // ready in the 16th ACCESS cycle completes without error.
      xfer(1'b0, uart_word_addr(UART_OPS), 32'h0, TO - 1, 32'h0000_5A5A);
      // Abort when ready never arrives within the limit.
      xfer(1'b0, uart_word_addr(UART_MODE), 32'h0, TO, 32'h0000_7777);

      // Reset in the middle of ACCESS.
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = uart_word_addr(UART_MODE);
      ready     = 1'b0;
      step();
      cmd_valid = 1'b0;
      step();
      chk("mid_en", en, 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_sel", sel, 64'd0);
      chk("mid_rst_en", en, 64'd0);
      chk("mid_rst_cmd_ready", cmd_ready, 64'd0);
      model_rd = '0;
      ready    = 1'b1;
      step();
      step();
      rstn = 1'b1;
      #1;
      chk("mid_rst_no_rsp", rsp_valid, 64'd0);
      chk("mid_rst_rdata", rsp_rdata, 64'(model_rd));
      step();
      chk("mid_rst_no_rsp2", rsp_valid, 64'd0);
      xfer(1'b0, uart_word_addr(UART_BAUD), 32'h0, 2, 32'hCAFE_0001);
      step();
      chk("final_rsp_single", rsp_valid, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
